// File: rtl/ir_hit_detector.sv
// IR beam-break hit detector: synchronizer, debounce FSM and hit counter.
// One hit_pulse per debounced CLEAR-to-BLOCKED transition.
module ir_hit_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_COUNT       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_sensor,
  input  logic       clear_count,
  output logic       object_present,
  output logic       hit_pulse,
  output logic [3:0] hit_count,
  output logic       count_wrap
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_CONFIRM_HIT,
    S_BLOCKED,
    S_CONFIRM_CLEAR
  } state_t;

  localparam logic [23:0] DEB  = 24'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  MAXC = 4'(MAX_COUNT);

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_stab;
  logic [23:0] w_stab_next;
  logic        w_hit;
  logic        w_obj_next;
  logic        r_obj;
  logic        r_pulse;
  logic [3:0]  r_count;
  logic        r_wrap;

  // Idle-high so a reset never looks like a blocked beam.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ir_sensor;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_stab_next = r_stab;
    w_hit       = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        if (!r_sync2) begin
          w_next      = S_CONFIRM_HIT;
          w_stab_next = 24'd1;
        end else begin
          w_stab_next = 24'd0;
        end
      end
      S_CONFIRM_HIT: begin
        if (r_sync2) begin
          w_next      = S_CLEAR;
          w_stab_next = 24'd0;
        end else if (r_stab == DEB) begin
          w_next      = S_BLOCKED;
          w_stab_next = 24'd0;
          w_hit       = 1'b1;
        end else begin
          w_stab_next = r_stab + 24'd1;
        end
      end
      S_BLOCKED: begin
        if (r_sync2) begin
          w_next      = S_CONFIRM_CLEAR;
          w_stab_next = 24'd1;
        end else begin
          w_stab_next = 24'd0;
        end
      end
      S_CONFIRM_CLEAR: begin
        if (!r_sync2) begin
          w_next      = S_BLOCKED;
          w_stab_next = 24'd0;
        end else if (r_stab == DEB) begin
          w_next      = S_CLEAR;
          w_stab_next = 24'd0;
        end else begin
          w_stab_next = r_stab + 24'd1;
        end
      end
      default: begin
        w_next      = S_CLEAR;
        w_stab_next = 24'd0;
      end
    endcase
  end

  assign w_obj_next = (w_next == S_BLOCKED) ||
                      (w_next == S_CONFIRM_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_stab  <= 24'd0;
      r_obj   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stab  <= w_stab_next;
      r_obj   <= w_obj_next;
      r_pulse <= w_hit;
    end
  end

  // A clear in the pulse cycle wins over the increment and the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear_count) begin
        r_count <= 4'd0;
      end else if (r_pulse) begin
        if (r_count == MAXC) begin
          r_count <= 4'd0;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + 4'd1;
        end
      end
    end
  end

  assign object_present = r_obj;
  assign hit_pulse      = r_pulse;
  assign hit_count      = r_count;
  assign count_wrap     = r_wrap;

endmodule
